// File: rtl/da_pkg.sv
// Shared helpers and defaults for the parallel distributed-arithmetic FIR.
package da_pkg;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    function automatic int lut_w(input int cw, input int l);
        return cw + clog2(l);
    endfunction

    function automatic int y_w(input int b, input int cw, input int l);
        return b + lut_w(cw, l);
    endfunction

    // c2=1, c1=3, c0=2; c0 sits in the LSBs
    localparam logic [11:0] COEF_DEF = {4'sd1, 4'sd3, 4'sd2};

endpackage

// File: rtl/da_lut.sv
// DA partial-product table: sum of the coefficients whose address bit is set.
module da_lut
    import da_pkg::*;
#(
    parameter int L  = 3,
    parameter int CW = 4
) (
    input  logic [L-1:0]                  addr_i,
    input  logic [L*CW-1:0]               coef_i,
    output logic signed [lut_w(CW,L)-1:0] sum_o
);

    localparam int LW = lut_w(CW, L);

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < L; k++) begin
            if (addr_i[k]) begin
                sum_o = sum_o + LW'($signed(coef_i[k*CW +: CW]));
            end
        end
    end

endmodule

// File: rtl/da_fir_par.sv
// Parallel DA FIR: one LUT per input bit-slice, weighted and summed,
// with the MSB slice subtracted for two's-complement samples.
module da_fir_par
    import da_pkg::*;
#(
    parameter int              L         = 3,
    parameter int              B         = 4,
    parameter int              CW        = 4,
    parameter int              PIPE      = 0,
    parameter logic [L*CW-1:0] COEF_INIT = COEF_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         x_valid,
    input  logic signed [B-1:0]          x_in,
    input  logic                         coef_we,
    input  logic [clog2(L)-1:0]          coef_addr,
    input  logic signed [CW-1:0]         coef_data,
    output logic                         y_valid,
    output logic signed [y_w(B,CW,L)-1:0] y
);

    localparam int LW = lut_w(CW, L);
    localparam int WY = y_w(B, CW, L);

    logic [L-1:0][B-1:0]  tap_q, tap_d;
    logic [L-1:0][CW-1:0] coef_q, coef_d;
    logic                 acc_q;
    logic [LW-1:0]        lut [B];
    logic [LW-1:0]        lut_s [B];
    logic                 stg_v;
    logic signed [WY-1:0] sum_d, y_q;
    logic                 y_valid_q;

    always_comb begin
        tap_d = tap_q;
        if (clear) begin
            tap_d = '0;
        end else if (x_valid) begin
            tap_d = {tap_q[L-2:0], x_in};
        end
    end

    always_comb begin
        coef_d = coef_q;
        if (coef_we && int'(coef_addr) < L) begin
            coef_d[coef_addr] = coef_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_q  <= '0;
            coef_q <= COEF_INIT;
            acc_q  <= 1'b0;
        end else begin
            tap_q  <= tap_d;
            coef_q <= coef_d;
            acc_q  <= x_valid & ~clear;
        end
    end

    // bit b of every tap addresses slice b's table
    for (genvar b = 0; b < B; b++) begin : g_slice
        logic [L-1:0] a;
        always_comb begin
            for (int k = 0; k < L; k++) begin
                a[k] = tap_q[k][b];
            end
        end
        da_lut #(.L(L), .CW(CW)) u_lut (
            .addr_i (a),
            .coef_i (coef_q),
            .sum_o  (lut[b])
        );
    end

    if (PIPE != 0) begin : g_pipe
        logic [LW-1:0] lut_q [B];
        logic          v_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int b = 0; b < B; b++) lut_q[b] <= '0;
                v_q <= 1'b0;
            end else if (clear) begin
                for (int b = 0; b < B; b++) lut_q[b] <= '0;
                v_q <= 1'b0;
            end else begin
                lut_q <= lut;
                v_q   <= acc_q;
            end
        end
        assign lut_s = lut_q;
        assign stg_v = v_q;
    end else begin : g_nopipe
        assign lut_s = lut;
        assign stg_v = acc_q;
    end

    always_comb begin
        sum_d = '0;
        for (int b = 0; b < B - 1; b++) begin
            sum_d = sum_d + (WY'($signed(lut_s[b])) << b);
        end
        sum_d = sum_d - (WY'($signed(lut_s[B-1])) << (B - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else if (clear) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= stg_v;
            if (stg_v) y_q <= sum_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_da_fir_par.sv
// Bench for da_fir_par: PIPE=0 and PIPE=1 instances against a convolution model.
module tb_da_fir_par;

    localparam int L  = 3;
    localparam int B  = 4;
    localparam int CW = 4;
    localparam int WY = 10;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 clear = 1'b0;
    logic                 x_valid = 1'b0;
    logic signed [B-1:0]  x_in = '0;
    logic                 coef_we = 1'b0;
    logic [1:0]           coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic                 yv0, yv1;
    logic signed [WY-1:0] y0, y1;

    always #5 clk = ~clk;

    da_fir_par #(.L(L), .B(B), .CW(CW), .PIPE(0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear),
        .x_valid(x_valid), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data),
        .y_valid(yv0), .y(y0)
    );

    da_fir_par #(.L(L), .B(B), .CW(CW), .PIPE(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .x_valid(x_valid), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data),
        .y_valid(yv1), .y(y1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // model: y[n] = sum_k c_k * x[n-k], due 1+p edges after acceptance
    typedef struct { int due; int val; } ent_t;
    ent_t q [2][$];
    int   hist [L];
    int   coef [L];
    int   ev [2];
    int   ey [2];
    int   cyc = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < L; k++) hist[k] = 0;
            coef = '{2, 3, 1};
            for (int p = 0; p < 2; p++) begin
                q[p].delete();
                ev[p] = 0;
                ey[p] = 0;
            end
        end else begin
            cyc++;
            if (clear) begin
                for (int k = 0; k < L; k++) hist[k] = 0;
                for (int p = 0; p < 2; p++) begin
                    q[p].delete();
                    ev[p] = 0;
                    ey[p] = 0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    ev[p] = 0;
                    if (q[p].size() > 0 && q[p][0].due == cyc) begin
                        ev[p] = 1;
                        ey[p] = q[p][0].val;
                        void'(q[p].pop_front());
                    end
                end
            end
            if (coef_we && int'(coef_addr) < L)
                coef[coef_addr] = int'(coef_data);
            if (x_valid && !clear) begin
                int acc;
                for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(x_in);
                acc = 0;
                for (int k = 0; k < L; k++) acc += coef[k] * hist[k];
                for (int p = 0; p < 2; p++)
                    q[p].push_back('{cyc + 1 + p, acc});
            end
        end
    end

    always @(negedge clk) begin
        chk("v0", int'(yv0), ev[0]);
        chk("y0", int'(y0), ey[0]);
        chk("v1", int'(yv1), ev[1]);
        chk("y1", int'(y1), ey[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int x);
        x_valid = v;
        x_in    = B'(x);
    endtask

    task automatic wr(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_data = CW'(d);
        drive(0, 0);
        step();
        coef_we = 1'b0;
    endtask

    task automatic flush();
        for (int i = 0; i < L; i++) begin
            drive(1, 0);
            step();
        end
        drive(0, 0);
        repeat (3) step();
    endtask

    task automatic run_seq(input string nm, input int n,
                           input int xs [8], input int ex [8]);
        for (int i = 0; i < n; i++) begin
            drive(1, xs[i]);
            step();
            if (i > 0) chk(nm, int'(y0), ex[i-1]);
        end
        drive(0, 0);
        step();
        chk(nm, int'(y0), ex[n-1]);
        repeat (2) step();
    endtask

    initial begin
        int pulses, first, last;

        repeat (2) step();
        chk("rst_y0", int'(y0), 0);
        chk("rst_v0", int'(yv0), 0);
        chk("rst_v1", int'(yv1), 0);
        reset = 1'b1;
        step();

        // impulse, both latencies
        drive(1, 1); step();
        drive(1, 0); step();
        chk("imp0", int'(y0), 2);
        step();
        chk("imp0", int'(y0), 3);
        chk("imp1", int'(y1), 2);
        step();
        chk("imp0", int'(y0), 1);
        chk("imp1", int'(y1), 3);
        step();
        chk("imp0", int'(y0), 0);
        chk("imp1", int'(y1), 1);
        drive(0, 0);
        repeat (3) step();

        // gapped input on the pipelined instance
        pulses = 0; first = -1; last = -1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || i == 2) drive(1, 1);
            else drive(0, 0);
            step();
            if (yv1) begin
                pulses++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("gap_n", pulses, 2);
        chk("gap_sp", last - first, 2);
        flush();

        run_seq("negfs", 4, '{-8, 0, 0, 0, 0, 0, 0, 0},
                '{-16, -24, -8, 0, 0, 0, 0, 0});
        run_seq("steady", 4, '{-8, -8, -8, -8, 0, 0, 0, 0},
                '{-16, -40, -48, -48, 0, 0, 0, 0});
        flush();

        // coefficient write on the same edge as a sample
        coef_we = 1'b1; coef_addr = 2'd1; coef_data = -4'sd8;
        drive(1, -8); step();
        coef_we = 1'b0;
        drive(1, 0); step();
        chk("cw", int'(y0), -16);
        step();
        chk("cw", int'(y0), 64);
        step();
        chk("cw", int'(y0), -8);
        drive(0, 0); step();
        chk("cw", int'(y0), 0);
        repeat (2) step();
        wr(3, 7);
        run_seq("cw_oob", 3, '{1, 0, 0, 0, 0, 0, 0, 0},
                '{2, -8, 1, 0, 0, 0, 0, 0});
        wr(1, 3);

        // clear beats x_valid
        drive(1, 5); step();
        drive(1, 5); step();
        clear = 1'b1;
        drive(1, 7); step();
        clear = 1'b0;
        chk("clr_v0", int'(yv0), 0);
        chk("clr_y0", int'(y0), 0);
        chk("clr_v1", int'(yv1), 0);
        drive(0, 0); step();
        chk("clr_v0b", int'(yv0), 0);
        chk("clr_v1b", int'(yv1), 0);
        run_seq("clr_imp", 3, '{1, 0, 0, 0, 0, 0, 0, 0},
                '{2, 3, 1, 0, 0, 0, 0, 0});

        // async reset mid-stream restores coefficients
        wr(0, -3);
        drive(1, 3); step();
        drive(1, 4); step();
        drive(0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_y0", int'(y0), 0);
        chk("arst_v0", int'(yv0), 0);
        chk("arst_y1", int'(y1), 0);
        chk("arst_v1", int'(yv1), 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        run_seq("arst_imp", 3, '{1, 0, 0, 0, 0, 0, 0, 0},
                '{2, 3, 1, 0, 0, 0, 0, 0});

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            clear     = ($urandom % 32) == 0;
            coef_we   = !clear && ($urandom % 10) == 0;
            coef_addr = 2'($urandom % 4);
            coef_data = CW'($urandom);
            x_valid   = ($urandom % 10) < 7;
            x_in      = B'($urandom);
            step();
        end
        clear = 1'b0;
        coef_we = 1'b0;
        drive(0, 0);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/da_fir_par.md
Name: da_fir_par

Overview:
Parametrised parallel distributed-arithmetic (DA) FIR filter, the next generation of our fixed 3-tap, 4-bit parallel DA filter.
- Each input bit-slice addresses its own DA partial-product table, one slice per input bit.
- The slice results are weighted by 2^b and summed; the MSB slice is subtracted (two's-complement input).
- New over the fixed version: generic tap count and widths, run-time coefficient loading, a valid handshake, synchronous clear, and an optional pipeline stage in front of the adder tree.
- Sits in the FIR datapath between the sample source and the output scaler.

Parameters:
- L, 3, number of taps (2..8).
- B, 4, input sample width, signed two's complement (2..16).
- CW, 4, coefficient width, signed.
- PIPE, 0, 0 = no stage before the adder tree; 1 = register the B LUT outputs before the adder tree.
- COEF_INIT, {4'sd1,4'sd3,4'sd2}, L*CW packed reset coefficients; c0 in the LSBs, c0 applies to the newest sample.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- clear, in, 1, synchronous flush of taps and pipeline; coefficients are kept.
- x_valid, in, 1, x_in is accepted on this edge.
- x_in, in, B, input sample, signed.
- coef_we, in, 1, coefficient write strobe.
- coef_addr, in, clog2(L), index of the tap to write.
- coef_data, in, CW, new coefficient, signed.
- y_valid, out, 1, one-cycle pulse per accepted sample.
- y, out, WY = B+CW+clog2(L), filter output, signed.

Behaviour:
- Reset (reset=0, asynchronous):
  - taps := 0; coefficients := COEF_INIT.
  - pipeline registers := 0; y := 0; y_valid := 0.
- Tap line:
  - On an edge with x_valid=1 and clear=0: tap[0] := x_in and tap[k] := tap[k-1] for k = 1..L-1.
  - With x_valid=0 the taps hold.
- Per-slice LUT:
  - For slice b = 0..B-1, address a_b[k] = tap[k][b].
  - lut_b = sum over k of (a_b[k] ? c_k : 0), sign-extended to CW+clog2(L) bits.
- Output arithmetic:
  - y = sum over b = 0..B-2 of (lut_b << b), minus (lut_{B-1} << (B-1)).
  - All terms are sign-extended to WY before summing. With WY sized as above there is no overflow and no saturation.
- Latency:
  - A sample accepted at edge E0 produces y and y_valid=1 at edge E0+1+PIPE.
  - y_valid is high for exactly one cycle per accepted sample.
  - y holds its last value while y_valid=0.
  - Back-to-back x_valid gives one output per cycle (full throughput).
- Coefficients:
  - coef_we=1 writes coef_data into c[coef_addr] at the edge.
  - If coef_addr >= L the write is ignored.
  - A write and x_valid on the same edge: that sample's output uses the NEW coefficient, because the LUT reads the registered coefficients after the edge.
  - With PIPE=1, samples already in the pipeline register keep their old partial sums.
- Clear:
  - clear=1 zeroes the taps, the PIPE stage and y_valid at the edge; y is zeroed as well.
  - clear beats x_valid: a sample presented with clear=1 is dropped and produces no y_valid.
  - Coefficients are unaffected by clear.
- Reset during operation: outputs go to their reset values immediately; in-flight samples are lost and produce no y_valid.

Decomposition:
- Package da_pkg:
  - clog2 function.
  - Width helpers: lut_w(CW,L) = CW+clog2(L) and y_w(B,CW,L).
  - Default coefficient constant.
- Sub-module da_lut:
  - Combinational.
  - Inputs: L-bit address and the L*CW coefficient vector. Output: lut_w-bit signed sum.
  - Instantiated B times via generate.
- The top level holds the tap registers, coefficient registers, optional pipeline stage, adder tree and valid pipeline.

Test Plan (defaults L=3, B=4, CW=4, coefficients c0=2, c1=3, c2=1, WY=10):
1. Impulse: x_valid every cycle with x_in = 1,0,0,0,0 → y = 2,3,1,0,0, each at E0+1, y_valid high for 5 cycles.
2. Negative full-scale: x_in = -8,0,0,0 → y = -16,-24,-8,0. Constant x_in=-8 for 4 samples → steady y = -48.
3. Coefficient load: write c1 = -8 (coef_addr=1), same edge as x_in=-8, then zeros → y = -16,+64,-8. A write to coef_addr=3 changes nothing.
4. PIPE=1: repeat test 1 → identical values, each appearing one cycle later (edge E0+2). Gap the input (x_valid 1,0,1) → exactly two y_valid pulses, spacing preserved.
5. Clear: after samples 5,5, assert clear together with x_valid and x_in=7 → no y_valid for x_in=7; the next impulse x_in=1 → y = 2,3,1 (no residue from 5,5). Coefficients are retained.
6. Async reset: drop reset mid-stream between edges → y=0 and y_valid=0 immediately, coefficients back to 2,3,1. After release, impulse → 2,3,1.
